// File: rtl/jump_address_loader.sv
// Fetches a two-byte jump operand over the W bus and parallel-loads the PC.
// A not-taken jump simply steps the PC past the operand bytes.
module jump_address_loader #(
    parameter int unsigned pTIMEOUT = 15
) (
    input  logic        inCLK,
    input  logic        inRST,
    input  logic        inStart,
    input  logic        inCondition,
    input  logic        inByteValid,
    input  logic [7:0]  inWbus,
    output logic        outRequest,
    output logic        outINC,
    output logic [15:0] outData,
    output logic        outPRST,
    output logic        outBusy,
    output logic        outDone,
    output logic        outError
);

    localparam logic [7:0] LP_TIMEOUT = 8'(pTIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        LOAD,
        SKIP1,
        SKIP2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_lo;
    logic [7:0]  r_cnt;
    logic [15:0] r_data;
    logic        r_request;
    logic        r_prst;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic w_in_req;
    logic w_timeout;
    logic w_next_req;

    assign w_in_req   = (r_state == REQ_LO) || (r_state == REQ_HI);
    assign w_timeout  = w_in_req && !inByteValid && (r_cnt == LP_TIMEOUT);
    assign w_next_req = (w_next == REQ_LO) || (w_next == REQ_HI);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (inStart)
                    w_next = inCondition ? REQ_LO : SKIP1;
            end
            REQ_LO: begin
                if (inByteValid)
                    w_next = REQ_HI;
                else if (w_timeout)
                    w_next = IDLE;
            end
            REQ_HI: begin
                if (inByteValid)
                    w_next = LOAD;
                else if (w_timeout)
                    w_next = IDLE;
            end
            LOAD:    w_next = IDLE;
            SKIP1:   w_next = SKIP2;
            SKIP2:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_state   <= IDLE;
            r_lo      <= 8'h00;
            r_cnt     <= 8'h00;
            r_data    <= 16'h0000;
            r_request <= 1'b0;
            r_prst    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_request <= w_next_req;
            r_prst    <= (w_next == LOAD);
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == LOAD) || (w_next == SKIP2);
            r_error   <= w_timeout;

            if (w_next_req && (w_next != r_state))
                r_cnt <= 8'h00;
            else if (w_in_req && !inByteValid && !w_timeout)
                r_cnt <= r_cnt + 8'h01;

            if ((r_state == REQ_LO) && inByteValid)
                r_lo <= inWbus;
            // High byte lands straight in the PC load register with the low byte.
            if ((r_state == REQ_HI) && inByteValid)
                r_data <= {inWbus, r_lo};
        end
    end

    assign outINC     = (w_in_req && inByteValid)
                     || (r_state == SKIP1)
                     || (r_state == SKIP2);
    assign outRequest = r_request;
    assign outData    = r_data;
    assign outPRST    = r_prst;
    assign outBusy    = r_busy;
    assign outDone    = r_done;
    assign outError   = r_error;

endmodule

// File: tb/tb_jump_address_loader.sv
// Bench for jump_address_loader: per-cycle output timeline derived from
// operand wait counts, randomized operands, waits and idle-time noise.
module tb_jump_address_loader;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cond;
    logic        bv;
    logic [7:0]  wbus;
    logic        o_req;
    logic        o_inc;
    logic [15:0] o_data;
    logic        o_prst;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_data = 16'h0000;

    jump_address_loader #(.pTIMEOUT(TO)) dut (
        .inCLK       (clk),
        .inRST       (rst),
        .inStart     (start),
        .inCondition (cond),
        .inByteValid (bv),
        .inWbus      (wbus),
        .outRequest  (o_req),
        .outINC      (o_inc),
        .outData     (o_data),
        .outPRST     (o_prst),
        .outBusy     (o_busy),
        .outDone     (o_done),
        .outError    (o_err)
    );

    always #5 clk = ~clk;

    // Expected {req,inc,prst,done,err,busy} k cycles after the start cycle.
    // w0/w1: idle cycles before each byte; more than TO means never supplied.
    function automatic logic [5:0] expect_at(bit c, int w0, int w1, int k);
        int b0;
        int b1;
        b0 = w0 + 1;
        b1 = w0 + w1 + 2;
        if (k < 1) return 6'b000000;
        if (!c) begin
            if (k == 1) return 6'b010001;
            if (k == 2) return 6'b010101;
            return 6'b000000;
        end
        if (w0 > TO) begin
            if (k <= TO + 1) return 6'b100001;
            if (k == TO + 2) return 6'b000010;
            return 6'b000000;
        end
        if (k < b0) return 6'b100001;
        if (k == b0) return 6'b110001;
        if (w1 > TO) begin
            if (k <= b0 + TO + 1) return 6'b100001;
            if (k == b0 + TO + 2) return 6'b000010;
            return 6'b000000;
        end
        if (k < b1) return 6'b100001;
        if (k == b1) return 6'b110001;
        if (k == b1 + 1) return 6'b001101;
        return 6'b000000;
    endfunction

    function automatic int op_len(bit c, int w0, int w1);
        if (!c) return 3;
        if (w0 > TO) return TO + 3;
        if (w1 > TO) return w0 + TO + 4;
        return w0 + w1 + 4;
    endfunction

    task automatic run_op(input bit c, input logic [7:0] lo,
                          input logic [7:0] hi, input int w0,
                          input int w1, input bit noise);
        int          last;
        int          dones;
        int          exp_dones;
        logic [5:0]  e;
        logic [5:0]  got;
        last  = op_len(c, w0, w1);
        dones = 0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            e   = expect_at(c, w0, w1, k);
            rst = 1'b0;
            if (k == 0) begin
                start = 1'b1;
                cond  = c;
            end else begin
                start = (noise && e[0]) ? 1'($urandom) : 1'b0;
                cond  = 1'($urandom);
            end
            if (e[5]) begin
                bv   = e[4];
                wbus = e[4] ? ((k == w0 + 1) ? lo : hi) : 8'($urandom);
            end else begin
                bv   = noise ? 1'($urandom) : 1'b0;
                wbus = 8'($urandom);
            end
            if (c && w0 <= TO && w1 <= TO && k == w0 + w1 + 3)
                exp_data = {hi, lo};
            #1;
            got = {o_req, o_inc, o_prst, o_done, o_err, o_busy};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL ctrl c=%0d w0=%0d w1=%0d k=%0d got=%b want=%b",
                         c, w0, w1, k, got, e);
            end
            total++;
            if (o_data !== exp_data) begin
                bad++;
                $display("FAIL data c=%0d k=%0d got=%h want=%h",
                         c, k, o_data, exp_data);
            end
            if (o_done) dones++;
        end
        exp_dones = (c && (w0 > TO || w1 > TO)) ? 0 : 1;
        total++;
        if (dones !== exp_dones) begin
            bad++;
            $display("FAIL done_count got=%0d want=%0d", dones, exp_dones);
        end
        start = 1'b0;
        bv    = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        got = {o_req, o_inc, o_prst, o_done, o_err, o_busy};
        total++;
        if (got !== 6'b000000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", got);
        end
        total++;
        if (o_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got=%h want=0000", o_data);
        end
        exp_data = 16'h0000;
    endtask

    task automatic test_taken();
        run_op(1'b1, 8'h34, 8'h12, 0, 0, 1'b0);
    endtask

    task automatic test_not_taken();
        run_op(1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_wait_states();
        run_op(1'b1, 8'hCD, 8'hAB, 3, 3, 1'b0);
    endtask

    task automatic test_timeout();
        run_op(1'b1, 8'h55, 8'h66, 1, TO + 1, 1'b0);
        run_op(1'b1, 8'h77, 8'h88, TO + 1, 0, 1'b0);
        run_op(1'b1, 8'h9A, 8'hBC, TO, TO, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        @(negedge clk);
        start = 1'b1;
        cond  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bv    = 1'b1;
        wbus  = 8'hFF;
        @(negedge clk);
        bv  = 1'b0;
        rst = 1'b1;
        exp_data = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst = 1'b0;
            bv  = 1'b0;
            #1;
            got = {o_req, o_inc, o_prst, o_done, o_err, o_busy};
            total++;
            if (got !== 6'b000000) begin
                bad++;
                $display("FAIL reset_mid_ctrl k=%0d got=%b", k, got);
            end
            total++;
            if (o_data !== exp_data) begin
                bad++;
                $display("FAIL reset_mid_data k=%0d got=%h want=%h",
                         k, o_data, exp_data);
            end
        end
    endtask

    task automatic test_restart();
        @(negedge clk);
        rst = 1'b1;
        exp_data = 16'h0000;
        run_op(1'b1, 8'h21, 8'h43, 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op(1'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    endtask

    task automatic test_random();
        int w0;
        int w1;
        for (int i = 0; i < 25; i++) begin
            w0 = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1)
                                             : $urandom_range(0, 4);
            w1 = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1)
                                             : $urandom_range(0, 4);
            run_op(1'($urandom), 8'($urandom), 8'($urandom), w0, w1,
                   1'($urandom));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cond  = 1'b0;
        bv    = 1'b0;
        wbus  = 8'h00;
        test_reset();
        test_taken();
        test_not_taken();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
